// File: rtl/tl_ul_sram_responder.sv
// TileLink-UL responder backed by a 64-bit-wide flop-array scratchpad.
// Ports: clock/reset (sync, active-high); auto_in_a_* request channel in
// (opcode/size/source/address/mask/data, valid/ready); auto_in_d_* response
// channel out (opcode/size/source/data, valid/ready) fed from a 2-entry queue.
// Optional err_count (8-bit saturating error counter) when TL_SRAM_ERRCNT_EN
// is defined; without the macro the port and counter are absent.
module tl_ul_sram_responder #(
    parameter int DEPTH = 64
) (
    input  logic        clock,
    input  logic        reset,
    output logic        auto_in_a_ready,
    input  logic        auto_in_a_valid,
    input  logic [2:0]  auto_in_a_bits_opcode,
    input  logic [1:0]  auto_in_a_bits_size,
    input  logic [8:0]  auto_in_a_bits_source,
    input  logic [11:0] auto_in_a_bits_address,
    input  logic [7:0]  auto_in_a_bits_mask,
    input  logic [63:0] auto_in_a_bits_data,
    input  logic        auto_in_d_ready,
    output logic        auto_in_d_valid,
    output logic [2:0]  auto_in_d_bits_opcode,
    output logic [1:0]  auto_in_d_bits_size,
    output logic [8:0]  auto_in_d_bits_source,
    output logic [63:0] auto_in_d_bits_data
`ifdef TL_SRAM_ERRCNT_EN
    ,
    output logic [7:0]  err_count
`endif
);

    localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    typedef struct packed {
        logic [2:0]  opcode;
        logic [1:0]  size;
        logic [8:0]  source;
        logic [63:0] data;
    } rsp_t;

    // state
    logic [63:0] mem_q [DEPTH];
    logic [63:0] mem_d [DEPTH];
    rsp_t        q_q [2];
    rsp_t        q_d [2];
    logic [1:0]  count_q, count_d;
    logic        wr_ptr_q, wr_ptr_d;
    logic        rd_ptr_q, rd_ptr_d;

    // request decode
    logic [8:0]    idx;
    logic [AW-1:0] word_idx;
    logic          in_range;
    logic [63:0]   rd_word;
    logic          a_fire, d_fire;
    logic          wr_en;
    logic          req_err;
    rsp_t          rsp;
    rsp_t          head;

    // byte-offset bits never select a word; the data path is a full 64 bits
    logic unused_addr_lsb;
    assign unused_addr_lsb = ^auto_in_a_bits_address[2:0];

    assign idx      = auto_in_a_bits_address[11:3];
    assign word_idx = idx[AW-1:0];
    assign in_range = ({23'd0, idx} < 32'(DEPTH));
    assign rd_word  = in_range ? mem_q[word_idx] : 64'd0;

    // no bypass: a full queue stalls A even if D is draining this cycle
    assign auto_in_a_ready = (count_q < 2'd2);
    assign auto_in_d_valid = (count_q != 2'd0);
    assign a_fire = auto_in_a_valid && auto_in_a_ready;
    assign d_fire = auto_in_d_valid && auto_in_d_ready;

    always_comb begin
        rsp        = '0;
        rsp.size   = auto_in_a_bits_size;
        rsp.source = auto_in_a_bits_source;
        wr_en      = 1'b0;
        req_err    = !in_range;
        unique case (auto_in_a_bits_opcode)
            3'd4: begin
                rsp.opcode = 3'd1;
                rsp.data   = rd_word;
            end
            3'd0, 3'd1: begin
                rsp.opcode = 3'd0;
                wr_en      = in_range;
            end
            3'd5: begin
                rsp.opcode = 3'd2;
            end
            default: begin
                rsp.opcode = 3'd0;
                req_err    = 1'b1;
            end
        endcase
    end

    always_comb begin
        mem_d = mem_q;
        if (a_fire && wr_en) begin
            for (int b = 0; b < 8; b++) begin
                if (auto_in_a_bits_mask[b]) begin
                    mem_d[word_idx][8*b +: 8] = auto_in_a_bits_data[8*b +: 8];
                end
            end
        end
    end

    always_comb begin
        q_d      = q_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q + {1'b0, a_fire} - {1'b0, d_fire};
        if (a_fire) begin
            q_d[wr_ptr_q] = rsp;
            wr_ptr_d      = ~wr_ptr_q;
        end
        if (d_fire) begin
            rd_ptr_d = ~rd_ptr_q;
        end
    end

    // array is deliberately not reset; writes are blocked while in reset
    always_ff @(posedge clock) begin
        if (!reset) begin
            mem_q <= mem_d;
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            q_q[0]   <= '0;
            q_q[1]   <= '0;
            count_q  <= 2'd0;
            wr_ptr_q <= 1'b0;
            rd_ptr_q <= 1'b0;
        end else begin
            q_q      <= q_d;
            count_q  <= count_d;
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
        end
    end

    assign head = auto_in_d_valid ? q_q[rd_ptr_q] : '0;
    assign auto_in_d_bits_opcode = head.opcode;
    assign auto_in_d_bits_size   = head.size;
    assign auto_in_d_bits_source = head.source;
    assign auto_in_d_bits_data   = head.data;

`ifdef TL_SRAM_ERRCNT_EN
    logic [7:0] err_q, err_d;

    always_comb begin
        err_d = err_q;
        if (a_fire && req_err && (err_q != 8'hFF)) begin
            err_d = err_q + 8'd1;
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            err_q <= 8'd0;
        end else begin
            err_q <= err_d;
        end
    end

    assign err_count = err_q;
`else
    logic unused_err;
    assign unused_err = req_err;
`endif

endmodule

// File: tb/tb_tl_ul_sram_responder.sv
// Directed self-checking bench for tl_ul_sram_responder (DEPTH=64).
// Inputs change 1 time unit after each rising edge; outputs checked there too.
module tb_tl_ul_sram_responder;

    logic        clock = 1'b0;
    logic        reset;
    logic        a_ready;
    logic        a_valid;
    logic [2:0]  a_opcode;
    logic [1:0]  a_size;
    logic [8:0]  a_source;
    logic [11:0] a_address;
    logic [7:0]  a_mask;
    logic [63:0] a_data;
    logic        d_ready;
    logic        d_valid;
    logic [2:0]  d_opcode;
    logic [1:0]  d_size;
    logic [8:0]  d_source;
    logic [63:0] d_data;
`ifdef TL_SRAM_ERRCNT_EN
    logic [7:0]  err_count;
`endif

    int n_vec = 0;
    int n_err = 0;

    tl_ul_sram_responder #(.DEPTH(64)) dut (
        .clock                  (clock),
        .reset                  (reset),
        .auto_in_a_ready        (a_ready),
        .auto_in_a_valid        (a_valid),
        .auto_in_a_bits_opcode  (a_opcode),
        .auto_in_a_bits_size    (a_size),
        .auto_in_a_bits_source  (a_source),
        .auto_in_a_bits_address (a_address),
        .auto_in_a_bits_mask    (a_mask),
        .auto_in_a_bits_data    (a_data),
        .auto_in_d_ready        (d_ready),
        .auto_in_d_valid        (d_valid),
        .auto_in_d_bits_opcode  (d_opcode),
        .auto_in_d_bits_size    (d_size),
        .auto_in_d_bits_source  (d_source),
        .auto_in_d_bits_data    (d_data)
`ifdef TL_SRAM_ERRCNT_EN
        ,
        .err_count              (err_count)
`endif
    );

    always #5 clock = ~clock;

    task automatic chk(input string tag, input logic [63:0] obs,
                       input logic [63:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic chk_d(input string tag, input logic [2:0] op,
                         input logic [8:0] src, input logic [1:0] sz,
                         input logic [63:0] dat);
        chk({tag, ".valid"}, {63'd0, d_valid}, 64'd1);
        chk({tag, ".op"}, {61'd0, d_opcode}, {61'd0, op});
        chk({tag, ".src"}, {55'd0, d_source}, {55'd0, src});
        chk({tag, ".size"}, {62'd0, d_size}, {62'd0, sz});
        chk({tag, ".data"}, d_data, dat);
    endtask

    task automatic cyc();
        @(posedge clock);
        #1;
    endtask

    task automatic req(input logic [2:0] op, input logic [11:0] addr,
                       input logic [7:0] mask, input logic [63:0] dat,
                       input logic [8:0] src, input logic [1:0] sz);
        a_valid   = 1'b1;
        a_opcode  = op;
        a_address = addr;
        a_mask    = mask;
        a_data    = dat;
        a_source  = src;
        a_size    = sz;
    endtask

    task automatic idle();
        a_valid = 1'b0;
        a_opcode = 3'd4;
        a_address = 12'd0;
        a_mask = 8'd0;
        a_data = 64'd0;
        a_source = 9'd0;
        a_size = 2'd0;
    endtask

    initial begin
        reset = 1'b1;
        d_ready = 1'b1;
        idle();
        cyc();
        cyc();
        // reset state
        chk("rst.d_valid", {63'd0, d_valid}, 64'd0);
        chk("rst.a_ready", {63'd0, a_ready}, 64'd1);
        chk("rst.d_data", d_data, 64'd0);
        chk("rst.d_src", {55'd0, d_source}, 64'd0);
`ifdef TL_SRAM_ERRCNT_EN
        chk("rst.err", {56'd0, err_count}, 64'd0);
`endif
        reset = 1'b0;

        // 1: PutFull then Get, 1-cycle latency each
        req(3'd0, 12'h010, 8'hFF, 64'h1122334455667788, 9'd7, 2'd3);
        chk("t1.a_ready", {63'd0, a_ready}, 64'd1);
        cyc();
        chk_d("t1.ack", 3'd0, 9'd7, 2'd3, 64'd0);
        req(3'd4, 12'h010, 8'hFF, 64'd0, 9'd9, 2'd3);
        cyc();
        chk_d("t1.get", 3'd1, 9'd9, 2'd3, 64'h1122334455667788);
        idle();
        cyc();
        chk("t1.drain", {63'd0, d_valid}, 64'd0);

        // 2: PutPartial low four bytes
        req(3'd1, 12'h010, 8'h0F, 64'hAAAAAAAA_BBBBBBBB, 9'd3, 2'd2);
        cyc();
        chk_d("t2.ack", 3'd0, 9'd3, 2'd2, 64'd0);
        req(3'd4, 12'h014, 8'hFF, 64'd0, 9'd4, 2'd3);
        cyc();
        chk_d("t2.get", 3'd1, 9'd4, 2'd3, 64'h11223344BBBBBBBB);
        req(3'd0, 12'h018, 8'hFF, 64'h0123456789ABCDEF, 9'd1, 2'd3);
        cyc();
        req(3'd0, 12'h020, 8'hFF, 64'hFEDCBA9876543210, 9'd2, 2'd3);
        cyc();
        idle();
        cyc();
        chk("t2.drain", {63'd0, d_valid}, 64'd0);

        // 3: backpressure, three Gets, in-order drain
        d_ready = 1'b0;
        req(3'd4, 12'h010, 8'hFF, 64'd0, 9'd10, 2'd3);
        cyc();
        req(3'd4, 12'h018, 8'hFF, 64'd0, 9'd11, 2'd3);
        chk("t3.rdy1", {63'd0, a_ready}, 64'd1);
        cyc();
        req(3'd4, 12'h020, 8'hFF, 64'd0, 9'd12, 2'd3);
        chk("t3.full", {63'd0, a_ready}, 64'd0);
        chk_d("t3.head", 3'd1, 9'd10, 2'd3, 64'h11223344BBBBBBBB);
        cyc();
        chk("t3.stall_rdy", {63'd0, a_ready}, 64'd0);
        chk_d("t3.stall", 3'd1, 9'd10, 2'd3, 64'h11223344BBBBBBBB);
        d_ready = 1'b1;
        cyc();
        chk_d("t3.r2", 3'd1, 9'd11, 2'd3, 64'h0123456789ABCDEF);
        chk("t3.rdy2", {63'd0, a_ready}, 64'd1);
        cyc();
        chk_d("t3.r3", 3'd1, 9'd12, 2'd3, 64'hFEDCBA9876543210);
        idle();
        cyc();
        chk("t3.drain", {63'd0, d_valid}, 64'd0);

        // 4: back-to-back Get stream
        for (int i = 0; i < 4; i++) begin
            req(3'd4, (i % 2 == 0) ? 12'h010 : 12'h018, 8'hFF, 64'd0,
                9'(20 + i), 2'd3);
            cyc();
            chk_d("t4.rsp", 3'd1, 9'(20 + i), 2'd3,
                  (i % 2 == 0) ? 64'h11223344BBBBBBBB : 64'h0123456789ABCDEF);
            chk("t4.a_ready", {63'd0, a_ready}, 64'd1);
        end
        idle();
        cyc();
        chk("t4.drain", {63'd0, d_valid}, 64'd0);

        // 5: out-of-range Get, unsupported opcode, Intent
        req(3'd4, 12'h400, 8'hFF, 64'd0, 9'd30, 2'd3);
        cyc();
        chk_d("t5.oor", 3'd1, 9'd30, 2'd3, 64'd0);
        req(3'd2, 12'h008, 8'hFF, 64'hFFFF, 9'd31, 2'd1);
        cyc();
        chk_d("t5.badop", 3'd0, 9'd31, 2'd1, 64'd0);
        req(3'd5, 12'h010, 8'hFF, 64'd0, 9'd32, 2'd0);
        cyc();
        chk_d("t5.hint", 3'd2, 9'd32, 2'd0, 64'd0);
`ifdef TL_SRAM_ERRCNT_EN
        chk("t5.err", {56'd0, err_count}, 64'd2);
`endif
        idle();
        cyc();

        // 6: reset with two queued responses
        d_ready = 1'b0;
        req(3'd4, 12'h010, 8'hFF, 64'd0, 9'd40, 2'd3);
        cyc();
        req(3'd4, 12'h018, 8'hFF, 64'd0, 9'd41, 2'd3);
        cyc();
        chk("t6.full", {63'd0, a_ready}, 64'd0);
        req(3'd4, 12'h020, 8'hFF, 64'd0, 9'd42, 2'd3);
        reset = 1'b1;
        cyc();
        chk("t6.d_valid", {63'd0, d_valid}, 64'd0);
        chk("t6.a_ready", {63'd0, a_ready}, 64'd1);
        chk("t6.d_src", {55'd0, d_source}, 64'd0);
`ifdef TL_SRAM_ERRCNT_EN
        chk("t6.err", {56'd0, err_count}, 64'd0);
`endif
        cyc();
        chk("t6.no_accept", {63'd0, d_valid}, 64'd0);
        reset = 1'b0;
        idle();
        d_ready = 1'b1;
        cyc();
        chk("t6.idle", {63'd0, d_valid}, 64'd0);
        // array contents survive reset
        req(3'd4, 12'h010, 8'hFF, 64'd0, 9'd50, 2'd3);
        cyc();
        chk_d("t6.keep", 3'd1, 9'd50, 2'd3, 64'h11223344BBBBBBBB);
        idle();
        cyc();

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
